// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth sequencer: state encoding, op codes,
// Booth pair codes and the registered control-strobe bundle.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    ARITH = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } booth_state_t;

  localparam logic       OP_ADD   = 1'b0;
  localparam logic       OP_SUB   = 1'b1;
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  typedef struct packed {
    logic ld_m;
    logic ld_q;
    logic clr_a;
    logic ld_a;
    logic addsub;
    logic sft;
    logic clr_ff;
    logic ld_ff;
    logic busy;
    logic done;
  } booth_ctrl_t;

  // Strobes are a pure function of state (and the latched op), so the
  // register holding them is exactly the Moore decode of the state register.
  function automatic booth_ctrl_t decode_ctrl(input booth_state_t st, input logic op);
    booth_ctrl_t c;
    c = '0;
    case (st)
      LOAD: begin
        c.ld_m   = 1'b1;
        c.ld_q   = 1'b1;
        c.clr_a  = 1'b1;
        c.clr_ff = 1'b1;
        c.busy   = 1'b1;
      end
      EVAL:  c.busy = 1'b1;
      ARITH: begin
        c.ld_a   = 1'b1;
        c.addsub = op;
        c.busy   = 1'b1;
      end
      SHIFT: begin
        c.sft   = 1'b1;
        c.ld_ff = 1'b1;
        c.busy  = 1'b1;
      end
      DONE: begin
        c.done = 1'b1;
        c.busy = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration down-counter: loads WIDTH, decrements once per shift,
// flags the final iteration (count == 1). Never wraps below zero.
module booth_iter_cnt #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(WIDTH);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier sequencer (Moore, registered strobes).
// Optional BOOTH_DONE_HOLD_EN: adds done_ack and holds DONE until it is seen.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic qm1,
`ifdef BOOTH_DONE_HOLD_EN
  input  logic done_ack,
`endif
  output logic ld_m,
  output logic ld_q,
  output logic clr_a,
  output logic ld_a,
  output logic addsub,
  output logic sft,
  output logic clr_ff,
  output logic ld_ff,
  output logic busy,
  output logic done
);

  booth_state_t state, state_nxt;
  logic         op, op_nxt;
  logic         cnt_last;
  booth_ctrl_t  ctrl;

  booth_iter_cnt #(.WIDTH(WIDTH)) u_iter_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (state == LOAD),
    .dec   (state == SHIFT),
    .last  (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = EVAL;
      EVAL: begin
        case ({q0, qm1})
          PAIR_ADD: begin
            state_nxt = ARITH;
            op_nxt    = OP_ADD;
          end
          PAIR_SUB: begin
            state_nxt = ARITH;
            op_nxt    = OP_SUB;
          end
          default:  state_nxt = SHIFT;
        endcase
      end
      ARITH: state_nxt = SHIFT;
      SHIFT: state_nxt = cnt_last ? DONE : EVAL;
`ifdef BOOTH_DONE_HOLD_EN
      DONE:  if (done_ack) state_nxt = IDLE;
`else
      DONE:  state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op    <= OP_ADD;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      ctrl  <= decode_ctrl(state_nxt, op_nxt);
    end
  end

  assign ld_m   = ctrl.ld_m;
  assign ld_q   = ctrl.ld_q;
  assign clr_a  = ctrl.clr_a;
  assign ld_a   = ctrl.ld_a;
  assign addsub = ctrl.addsub;
  assign sft    = ctrl.sft;
  assign clr_ff = ctrl.clr_ff;
  assign ld_ff  = ctrl.ld_ff;
  assign busy   = ctrl.busy;
  assign done   = ctrl.done;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: behavioural A/Q/M datapath plus Q(-1) register driven
// by the sequencer strobes, checked against hand-computed vectors.
module tb_booth_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic q0, qm1;
  logic ld_m, ld_q, clr_a, ld_a, addsub, sft, clr_ff, ld_ff, busy, done;
`ifdef BOOTH_DONE_HOLD_EN
  logic done_ack = 1'b0;
`endif

  booth_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .q0     (q0),
    .qm1    (qm1),
`ifdef BOOTH_DONE_HOLD_EN
    .done_ack (done_ack),
`endif
    .ld_m   (ld_m),
    .ld_q   (ld_q),
    .clr_a  (clr_a),
    .ld_a   (ld_a),
    .addsub (addsub),
    .sft    (sft),
    .clr_ff (clr_ff),
    .ld_ff  (ld_ff),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // A carries one guard bit so A-M cannot overflow when M = -2^(W-1).
  logic [W:0]   a_r = '0;
  logic [W-1:0] q_r = '0;
  logic [W-1:0] m_r = '0;
  logic         qm1_r = 1'b0;
  logic [W-1:0] m_in = '0;
  logic [W-1:0] q_in = '0;

  assign q0  = q_r[0];
  assign qm1 = qm1_r;

  always @(posedge clk) begin
    if (ld_m)   m_r   <= m_in;
    if (ld_q)   q_r   <= q_in;
    if (clr_a)  a_r   <= '0;
    if (clr_ff) qm1_r <= 1'b0;
    if (ld_a)   a_r   <= addsub ? a_r - {m_r[W-1], m_r} : a_r + {m_r[W-1], m_r};
    if (sft)    {a_r, q_r} <= {a_r[W], a_r, q_r[W-1:1]};
    if (ld_ff)  qm1_r <= q_r[0];
  end

  wire [9:0] outs = {ld_m, ld_q, clr_a, ld_a, addsub, sft, clr_ff, ld_ff, busy, done};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    bit          restart;
    logic [15:0] prod;
    int          lat;
    int          arith;
    logic [7:0]  ops;
  } vec_t;

  vec_t vt[7];

  // Launch one multiply, observe strobes at negedges until done, then watch
  // three more cycles for stray done/busy.
  task automatic run_op(input logic [7:0] m, input logic [7:0] q, input bit restart,
                        output logic [15:0] prod, output int lat, output int arith,
                        output int dones, output logic [7:0] ops, output logic post_busy);
    m_in = m;
    q_in = q;
    lat = -1;
    arith = 0;
    dones = 0;
    ops = '0;
    prod = '0;
    post_busy = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (restart && k == 2) begin
        start = 1'b1;
        m_in = ~m;
        q_in = ~q;
      end
      if (restart && k == 3) start = 1'b0;
      if (ld_a) begin
        arith++;
        ops = {ops[6:0], addsub};
      end
      if (done) begin
        lat = k;
        dones++;
        prod = {a_r[W-1:0], q_r};
`ifdef BOOTH_DONE_HOLD_EN
        done_ack = 1'b1;
`endif
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
`ifdef BOOTH_DONE_HOLD_EN
      done_ack = 1'b0;
`endif
      if (done) dones++;
      post_busy = post_busy | busy;
    end
  endtask

  initial begin
    logic [15:0] prod;
    logic [7:0]  ops;
    logic        pb;
    int          lat, arith, dones;

    vt[0] = '{8'h07, 8'hFD, 1'b0, 16'hFFEB, 21, 3, 8'h05};
    vt[1] = '{8'h55, 8'h00, 1'b0, 16'h0000, 18, 0, 8'h00};
    vt[2] = '{8'h03, 8'h55, 1'b0, 16'h00FF, 26, 8, 8'hAA};
    vt[3] = '{8'h13, 8'h0B, 1'b1, 16'h00D1, 22, 4, 8'h0A};
    vt[4] = '{8'hFF, 8'h7F, 1'b0, 16'hFF81, 20, 2, 8'h02};
    vt[5] = '{8'h7F, 8'h80, 1'b0, 16'hC080, 19, 1, 8'h01};
    vt[6] = '{8'h80, 8'h7F, 1'b0, 16'hC080, 20, 2, 8'h02};

    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outs", 32'(outs), 32'h0);

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].m, vt[i].q, vt[i].restart, prod, lat, arith, dones, ops, pb);
      chk($sformatf("v%0d_prod", i), 32'(prod), 32'(vt[i].prod));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_arith", i), 32'(arith), 32'(vt[i].arith));
      chk($sformatf("v%0d_ops", i), 32'(ops), 32'(vt[i].ops));
      chk($sformatf("v%0d_dones", i), 32'(dones), 32'd1);
      chk($sformatf("v%0d_busy_after", i), 32'(pb), 32'd0);
    end

    // Async reset while ld_a is asserted.
    m_in = 8'h07;
    q_in = 8'hFD;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ld_a) break;
      @(negedge clk);
    end
    chk("rst_reached_arith", 32'(ld_a), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_strobes_zero", 32'(outs), 32'h0);
    @(negedge clk);
    chk("rst_held_zero", 32'(outs), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    run_op(8'h80, 8'h80, 1'b0, prod, lat, arith, dones, ops, pb);
    chk("rst_relaunch_prod", 32'(prod), 32'h4000);
    chk("rst_relaunch_latency", 32'(lat), 32'd19);
    chk("rst_relaunch_dones", 32'(dones), 32'd1);

`ifdef BOOTH_DONE_HOLD_EN
    // Hold done for 5 cycles, try a start during the hold, then acknowledge.
    m_in = 8'h03;
    q_in = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("hold_done_%0d", i), 32'(done), 32'd1);
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
    end
    chk("hold_prod", 32'({a_r[W-1:0], q_r}), 32'h0000);
    done_ack = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
    chk("hold_ack_idle", 32'({busy, done}), 32'd0);
    @(negedge clk);
    chk("hold_start_ignored", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
